// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, function codes and default width for the calculator datapath
package calc_pkg;
    localparam int CALC_WIDTH = 8;
    typedef logic [1:0] alu_state_t;
    localparam alu_state_t IDLE = 2'd0;
    localparam alu_state_t LOAD = 2'd1;
    localparam alu_state_t RUN  = 2'd2;
    localparam alu_state_t DONE = 2'd3;
    localparam logic [2:0] FCT_ADD  = 3'd0;
    localparam logic [2:0] FCT_SUB  = 3'd1;
    localparam logic [2:0] FCT_MUL  = 3'd2;
    localparam logic [2:0] FCT_DIV  = 3'd3;
    localparam logic [2:0] FCT_AND  = 3'd4;
    localparam logic [2:0] FCT_OR   = 3'd5;
    localparam logic [2:0] FCT_XOR  = 3'd6;
    localparam logic [2:0] FCT_RSVD = 3'd7;
endpackage

// File: rtl/calc_div_step.sv
// calc_div_step: one combinational restoring-divide step
//   rem_i  partial remainder (always < div_i)
//   bit_i  next dividend bit shifted in
//   div_i  divisor
//   rem_o  next partial remainder
//   q_o    quotient bit produced by this step
module calc_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] sh;
    assign sh    = {rem_i, bit_i};
    assign q_o   = sh >= {1'b0, div_i};
    // when q_o is set the true difference is below div_i, so W-bit modulo subtraction is exact
    assign rem_o = q_o ? sh[WIDTH-1:0] - div_i : sh[WIDTH-1:0];
endmodule

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: multi-cycle ALU, 2-cycle simple ops, WIDTH-step shift-add MUL and restoring DIV
//   clock_i  rising-edge clock        reset_i  async active-low reset
//   start_i  request (IDLE/DONE only) a_i/b_i/fct_i  operands and function code
//   res_o    result                   rem_o  remainder / carry / high product
//   done_o   completion pulse         busy_o high in LOAD and RUN
//   err_o    error flag of last op, held
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,
    parameter int FCT_W = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [FCT_W-1:0] fct_i,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d, rem_q, rem_d;
    logic [FCT_W-1:0] fct_q, fct_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d, done_q, busy_q;

    logic [WIDTH:0]   sum_w, dif_w, mac_w;
    logic [WIDTH-1:0] alu_res, alu_rem, div_rem, step_acc, step_lo;
    logic             alu_err, div_q, iter;

    assign sum_w = {1'b0, a_q} + {1'b0, b_q};
    assign dif_w = {1'b0, a_q} - {1'b0, b_q};
    assign iter  = (fct_q == FCT_MUL) || (fct_q == FCT_DIV && b_q != '0);

    always_comb begin
        alu_res = '0;
        alu_rem = '0;
        alu_err = 1'b0;
        case (fct_q)
            FCT_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_rem = {{(WIDTH-1){1'b0}}, sum_w[WIDTH]};
            end
            FCT_SUB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_rem = {{(WIDTH-1){1'b0}}, dif_w[WIDTH]};
            end
            FCT_DIV: begin
                alu_res = '1;
                alu_rem = a_q;
                alu_err = 1'b1;
            end
            FCT_AND: alu_res = a_q & b_q;
            FCT_OR:  alu_res = a_q | b_q;
            FCT_XOR: alu_res = a_q ^ b_q;
            default: alu_err = 1'b1;
        endcase
    end

    // {acc,lo} shifts right each step: acc holds the running high product, lo the unused multiplier bits
    assign mac_w = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    calc_div_step #(.WIDTH(WIDTH)) u_div (
        .rem_i (acc_q),
        .bit_i (lo_q[WIDTH-1]),
        .div_i (b_q),
        .rem_o (div_rem),
        .q_o   (div_q)
    );

    // for DIV, lo shifts left: dividend bits leave the top, quotient bits enter the bottom
    assign step_acc = (fct_q == FCT_MUL) ? mac_w[WIDTH:1] : div_rem;
    assign step_lo  = (fct_q == FCT_MUL) ? {mac_w[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], div_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fct_d   = fct_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start_i ? LOAD : IDLE;
                if (start_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    fct_d = fct_i;
                end
            end
            LOAD: begin
                state_d = iter ? RUN : DONE;
                if (iter) begin
                    acc_d = '0;
                    lo_d  = a_q;
                    cnt_d = CW'(WIDTH - 1);
                end else begin
                    res_d = alu_res;
                    rem_d = alu_rem;
                    err_d = alu_err;
                end
            end
            default: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    res_d   = step_lo;
                    rem_d   = step_acc;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fct_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fct_q   <= fct_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= state_d == DONE;
            busy_q  <= state_d == LOAD || state_d == RUN;
        end
    end

    assign res_o  = res_q;
    assign rem_o  = rem_q;
    assign err_o  = err_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_calc_alu_seq.sv
// tb_calc_alu_seq: directed and randomised checks of calc_alu_seq against hand values and a reference model
module tb_calc_alu_seq;
    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] a_i = '0, b_i = '0;
    logic [2:0] fct_i = '0;
    logic [7:0] res_o, rem_o;
    logic       done_o, busy_o, err_o;
    int         errors = 0;
    int         checks = 0;

    calc_alu_seq #(.WIDTH(8), .FCT_W(3)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .fct_i   (fct_i),
        .res_o   (res_o),
        .rem_o   (rem_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        start_i = 1'b1;
        a_i = a;
        b_i = b;
        fct_i = f;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        fct_i = 3'($urandom);
    endtask

    // returns the cycle index (edge 0 = start sampled) at which done_o is seen, -1 on timeout
    task automatic wait_done(output int lat);
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock_i);
            #1;
            lat++;
            if (done_o) return;
        end
        lat = -1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({res_o, rem_o, done_o, busy_o, err_o} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%0h rem=%0h done=%b busy=%b err=%b, want all 0", res_o, rem_o, done_o, busy_o, err_o);
        end
        @(posedge clock_i);
        #1;
        reset_i = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        start_op(8'd200, 8'd100, 3'd0);
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL add_cycle1: got busy=%b done=%b, want busy=1 done=0", busy_o, done_o);
        end
        wait_done(lat);
        checks++;
        if (lat != 2 || res_o !== 8'd44 || rem_o !== 8'd1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got lat=%0d res=%0d rem=%0d err=%b busy=%b, want lat=2 res=44 rem=1 err=0 busy=0", lat, res_o, rem_o, err_o, busy_o);
        end
        @(posedge clock_i);
        #1;
        checks++;
        if (done_o !== 1'b0 || res_o !== 8'd44) begin
            errors++;
            $display("FAIL add_hold: got done=%b res=%0d, want done=0 res=44", done_o, res_o);
        end
    endtask

    task automatic test_mul;
        int dones = 0;
        int done_at = -1;
        int busy_bad = 0;
        start_op(8'd200, 8'd3, 3'd2);
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin
                @(posedge clock_i);
                #1;
            end
            if (busy_o !== (c <= 9)) busy_bad++;
            if (done_o) begin
                dones++;
                done_at = c;
            end
            if (c == 10) begin
                checks++;
                if (res_o !== 8'h58 || rem_o !== 8'h02 || err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_result: got res=%0h rem=%0h err=%b, want res=58 rem=02 err=0", res_o, rem_o, err_o);
                end
            end
            start_i = (c == 4);
            if (c == 4) begin
                a_i = 8'd1;
                b_i = 8'd1;
                fct_i = 3'd0;
            end
        end
        checks++;
        if (dones != 1 || done_at != 10) begin
            errors++;
            $display("FAIL mul_done: got pulses=%0d at=%0d, want pulses=1 at=10", dones, done_at);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL mul_busy: got %0d bad cycles, want 0", busy_bad);
        end
    endtask

    task automatic test_div;
        int lat;
        start_op(8'd100, 8'd7, 3'd3);
        wait_done(lat);
        checks++;
        if (lat != 10 || res_o !== 8'd14 || rem_o !== 8'd2 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL div_result: got lat=%0d res=%0d rem=%0d err=%b, want lat=10 res=14 rem=2 err=0", lat, res_o, rem_o, err_o);
        end
        start_op(8'd5, 8'd0, 3'd3);
        wait_done(lat);
        checks++;
        if (lat != 2 || res_o !== 8'hFF || rem_o !== 8'd5 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: got lat=%0d res=%0h rem=%0d err=%b, want lat=2 res=ff rem=5 err=1", lat, res_o, rem_o, err_o);
        end
    endtask

    task automatic test_back_to_back;
        start_i = 1'b1;
        a_i = 8'd3;
        b_i = 8'd5;
        fct_i = 3'd1;
        @(posedge clock_i);
        #1;
        a_i = 8'hF0;
        b_i = 8'hFF;
        fct_i = 3'd6;
        @(posedge clock_i);
        #1;
        checks++;
        if (done_o !== 1'b1 || res_o !== 8'hFE || rem_o !== 8'd1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sub: got done=%b res=%0h rem=%0d err=%b, want done=1 res=fe rem=1 err=0", done_o, res_o, rem_o, err_o);
        end
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load: got done=%b busy=%b, want done=0 busy=1", done_o, busy_o);
        end
        @(posedge clock_i);
        #1;
        checks++;
        if (done_o !== 1'b1 || res_o !== 8'h0F || rem_o !== 8'd0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_xor: got done=%b res=%0h rem=%0d err=%b, want done=1 res=0f rem=0 err=0", done_o, res_o, rem_o, err_o);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones = 0;
        start_op(8'd200, 8'd3, 3'd2);
        repeat (4) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({res_o, rem_o, done_o, busy_o, err_o} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid: got res=%0h rem=%0h done=%b busy=%b err=%b, want all 0", res_o, rem_o, done_o, busy_o, err_o);
        end
        repeat (10) begin
            @(posedge clock_i);
            #1;
            if (done_o) dones++;
        end
        reset_i = 1'b1;
        repeat (3) begin
            @(posedge clock_i);
            #1;
            if (done_o) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
        end
        start_op(8'd9, 8'd9, 3'd7);
        wait_done(lat);
        checks++;
        if (lat != 2 || res_o !== 8'd0 || rem_o !== 8'd0 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL rsvd: got lat=%0d res=%0h rem=%0h err=%b, want lat=2 res=0 rem=0 err=1", lat, res_o, rem_o, err_o);
        end
    endtask

    task automatic test_random;
        logic [7:0] a, b, er, em;
        logic [2:0] f;
        logic [15:0] w;
        logic ee;
        int el, lat;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            f = 3'($urandom);
            ee = 1'b0;
            el = 2;
            em = 8'd0;
            er = 8'd0;
            case (f)
                3'd0: begin w = 16'(a) + 16'(b); er = w[7:0]; em = {7'd0, w[8]}; end
                3'd1: begin er = a - b; em = {7'd0, a < b}; end
                3'd2: begin w = 16'(a) * 16'(b); er = w[7:0]; em = w[15:8]; el = 10; end
                3'd3: begin
                    if (b == 0) begin er = 8'hFF; em = a; ee = 1'b1; end
                    else begin er = a / b; em = a % b; el = 10; end
                end
                3'd4: er = a & b;
                3'd5: er = a | b;
                3'd6: er = a ^ b;
                default: ee = 1'b1;
            endcase
            start_op(a, b, f);
            wait_done(lat);
            checks++;
            if (lat != el || res_o !== er || rem_o !== em || err_o !== ee) begin
                errors++;
                $display("FAIL rand_op%0d f=%0d a=%0d b=%0d: got lat=%0d res=%0h rem=%0h err=%b, want lat=%0d res=%0h rem=%0h err=%b",
                         n, f, a, b, lat, res_o, rem_o, err_o, el, er, em, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
- Multi-cycle arithmetic unit directly downstream of the calculator control FSM.
- Consumes the latched operand A, operand B and function-code registers, and produces the result, remainder and done values.
- Those outputs are written by the FSM's res/rem/done register enables.
- Single-cycle ops finish in a fixed 2 cycles. MUL/DIV run iteratively (shift-add multiply, restoring divide) over WIDTH cycles.

Parameters:
- WIDTH, 8, operand/result width in bits (unsigned).
- FCT_W, 3, function-code width.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request; sampled only in IDLE or DONE.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- fct_i  in  FCT_W  function code.
- res_o  out  WIDTH  result.
- rem_o  out  WIDTH  remainder / carry / high product.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in LOAD and RUN.
- err_o  out  1  error flag for last operation; held.

Behaviour:
- Reset (async, reset_i=0): state=IDLE. res_o, rem_o, done_o, busy_o, err_o and all internal regs are 0. A reset mid-operation aborts immediately with no done pulse.
- States: IDLE, LOAD, RUN, DONE. Encoding comes from the shared package.
- Timing: cycle 0 is the edge at which start_i=1 is sampled in IDLE or DONE.
  - The next state is LOAD; a_i, b_i and fct_i are latched at that edge.
  - Inputs may change afterwards without effect.
- LOAD (cycle 1):
  - For ADD/SUB/AND/OR/XOR, reserved codes, or DIV with B=0: go to DONE.
  - For MUL and DIV with B≠0: initialise the accumulator/quotient/counter=WIDTH-1 and go to RUN.
- RUN: one shift-add or restore-subtract step per cycle. Go to DONE when counter=0, giving WIDTH cycles in RUN.
- DONE (1 cycle):
  - done_o=1; res_o, rem_o and err_o update on entry and are held until the next DONE.
  - Next state is LOAD if start_i=1, else IDLE (back-to-back supported).
- Latency: done_o is high in cycle 2 for single-cycle ops and in cycle WIDTH+2 for MUL/DIV.
- start_i in LOAD or RUN is ignored (no queueing).
- Function codes (all unsigned, modulo 2^WIDTH):
  - 0 ADD: res=(A+B)[WIDTH-1:0], rem=carry-out zero-extended.
  - 1 SUB: res=(A-B)[WIDTH-1:0], rem=borrow (1 when A<B).
  - 2 MUL: {rem,res} = 2*WIDTH-bit product (rem = high half).
  - 3 DIV: res=A/B, rem=A%B. If B=0: res=all-ones, rem=A, err=1.
  - 4 AND, 5 OR, 6 XOR: res=bitwise op, rem=0.
  - 7 reserved: res=0, rem=0, err=1.
- err_o=0 for all valid ops, set in DONE.
- busy_o is registered and equals (state==LOAD or state==RUN).
- No combinational path from inputs to outputs.

Decomposition:
- Package calc_pkg holds:
  - state typedef alu_state_t (IDLE, LOAD, RUN, DONE);
  - function-code constants FCT_ADD..FCT_XOR and FCT_RSVD;
  - default WIDTH.
- The FSM block's state encoding moves into the same package.
- One natural sub-module, calc_div_step: combinational single restoring-divide step (partial remainder, divisor → next remainder, quotient bit), reused per RUN cycle.
- The multiplier step stays inline.

Test Plan:
- ADD A=200,B=100 → cycle 2: done_o=1, res_o=44, rem_o=1, err_o=0, busy_o high only in cycle 1.
- MUL A=200,B=3 → done_o in cycle 10, res_o=0x58, rem_o=0x02; busy_o high cycles 1–9. start_i pulsed in cycle 5 is ignored (exactly one done_o).
- DIV A=100,B=7 → cycle 10: res_o=14, rem_o=2, err_o=0. Then DIV A=5,B=0 → done_o 2 cycles after start, res_o=0xFF, rem_o=5, err_o=1.
- Back-to-back: start_i held high through DONE of a SUB A=3,B=5 (res_o=0xFE, rem_o=1); next op XOR A=0xF0,B=0xFF is accepted at the DONE edge → res_o=0x0F, rem_o=0, done_o 2 cycles later.
- Reset asserted during RUN of MUL → all outputs 0 immediately, no done_o. After release, a start with fct_i=7 → res_o=0, err_o=1 at cycle 2.
- Random unsigned A/B over all valid codes (≥1000 ops) checked against a reference model for res_o, rem_o, err_o and latency.
